// File: rtl/wisc_pipe_pkg.sv
// Shared pipeline definitions: controller states, the zero register and
// forwarding select encodings.
package wisc_pipe_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        IMISS = 2'd1,
        DMISS = 2'd2
    } pipe_state_e;

    localparam logic [3:0] REG_ZERO = 4'h0;

    localparam logic [1:0] FWD_EX   = 2'b10;
    localparam logic [1:0] FWD_MEM  = 2'b01;
    localparam logic [1:0] FWD_NONE = 2'b00;

    // A producer only conflicts with a consumer when it names a real register.
    function automatic logic reg_match(input logic [3:0] producer, input logic [3:0] consumer);
        return (producer != REG_ZERO) && (producer == consumer);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use and branch-operand hazard decode for the ID stage.
// Optional feature: MEM_MEM_FWD_EN waives the store-data (rt-only) load-use stall.
module hazard_detect
    import wisc_pipe_pkg::*;
(
    input  logic [3:0] if_id_rs,
    input  logic [3:0] if_id_rt,
    input  logic       if_id_branch,
    input  logic       if_id_store,
    input  logic [3:0] id_ex_rd,
    input  logic       id_ex_write_reg,
    input  logic       id_ex_mem_read,
    input  logic [3:0] ex_mem_rd,
    input  logic       ex_mem_write_reg,
    output logic       load_use,
    output logic       branch_haz
);

`ifdef MEM_MEM_FWD_EN
    localparam logic MEM_FWD = 1'b1;
`else
    localparam logic MEM_FWD = 1'b0;
`endif

    logic rs_hit;
    logic rt_hit;
    logic rt_waived;
    logic br_ex_hit;
    logic br_mem_hit;

    always_comb begin
        rs_hit     = reg_match(id_ex_rd, if_id_rs);
        rt_hit     = reg_match(id_ex_rd, if_id_rt);
        // Store data can be forwarded MEM->MEM, so only an address (rs) use must wait.
        rt_waived  = MEM_FWD && if_id_store && !rs_hit;
        load_use   = id_ex_mem_read && (rs_hit || (rt_hit && !rt_waived));
        br_ex_hit  = id_ex_write_reg  && reg_match(id_ex_rd,  if_id_rs);
        br_mem_hit = ex_mem_write_reg && reg_match(ex_mem_rd, if_id_rs);
        branch_haz = if_id_branch && (br_ex_hit || br_mem_hit);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: cache-miss sequencing FSM, stall/flush muxing
// and saturating stall-cycle counter. Optional feature macro: MEM_MEM_FWD_EN.
module hazard_ctrl
    import wisc_pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  if_id_rs,
    input  logic [3:0]  if_id_rt,
    input  logic        if_id_branch,
    input  logic        if_id_store,
    input  logic [3:0]  id_ex_rd,
    input  logic        id_ex_write_reg,
    input  logic        id_ex_mem_read,
    input  logic [3:0]  ex_mem_rd,
    input  logic        ex_mem_write_reg,
    input  logic        branch_taken,
    input  logic        icache_miss,
    input  logic        dcache_miss,
    input  logic        mem_ready,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        id_ex_stall,
    output logic        ex_mem_stall,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        mem_wb_flush,
    output logic        mem_sel,
    output logic [15:0] stall_cycles
);

    pipe_state_e state_q, state_d;
    logic [15:0] stall_cycles_q, stall_cycles_d;
    logic        load_use;
    logic        branch_haz;
    logic        hz_stall;

    hazard_detect u_hazard_detect (
        .if_id_rs         (if_id_rs),
        .if_id_rt         (if_id_rt),
        .if_id_branch     (if_id_branch),
        .if_id_store      (if_id_store),
        .id_ex_rd         (id_ex_rd),
        .id_ex_write_reg  (id_ex_write_reg),
        .id_ex_mem_read   (id_ex_mem_read),
        .ex_mem_rd        (ex_mem_rd),
        .ex_mem_write_reg (ex_mem_write_reg),
        .load_use         (load_use),
        .branch_haz       (branch_haz)
    );

    assign hz_stall = load_use || branch_haz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= RUN;
            stall_cycles_q <= 16'h0000;
        end else begin
            state_q        <= state_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_stall  = 1'b0;
        ex_mem_stall = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;
        mem_sel      = 1'b0;

        case (state_q)
            RUN: begin
                if (hz_stall) begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (branch_taken) begin
                    if_id_flush = 1'b1;
                end
                if (dcache_miss) begin
                    state_d = DMISS;
                end else if (icache_miss) begin
                    state_d = IMISS;
                end
            end
            DMISS: begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_stall = 1'b1;
                mem_wb_flush = 1'b1;
                mem_sel      = 1'b1;
                if (mem_ready) begin
                    state_d = icache_miss ? IMISS : RUN;
                end
            end
            IMISS: begin
                pc_stall    = 1'b1;
                if_id_flush = 1'b1;
                // A data miss raised mid-ifetch freezes the back end but waits for the port.
                if (dcache_miss) begin
                    if_id_stall  = 1'b1;
                    id_ex_stall  = 1'b1;
                    ex_mem_stall = 1'b1;
                    mem_wb_flush = 1'b1;
                end
                if (mem_ready) begin
                    state_d = dcache_miss ? DMISS : RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (rst) begin
            pc_stall     = 1'b0;
            if_id_stall  = 1'b0;
            id_ex_stall  = 1'b0;
            ex_mem_stall = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_flush  = 1'b0;
            mem_wb_flush = 1'b0;
            mem_sel      = 1'b0;
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (pc_stall && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// traffic against a behavioural reference model.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  if_id_rs, if_id_rt, id_ex_rd, ex_mem_rd;
    logic        if_id_branch, if_id_store, id_ex_write_reg, id_ex_mem_read;
    logic        ex_mem_write_reg, branch_taken, icache_miss, dcache_miss, mem_ready;
    logic        pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
    logic        if_id_flush, id_ex_flush, mem_wb_flush, mem_sel;
    logic [15:0] stall_cycles;
    logic [7:0]  dut_out;

    hazard_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .if_id_rs         (if_id_rs),
        .if_id_rt         (if_id_rt),
        .if_id_branch     (if_id_branch),
        .if_id_store      (if_id_store),
        .id_ex_rd         (id_ex_rd),
        .id_ex_write_reg  (id_ex_write_reg),
        .id_ex_mem_read   (id_ex_mem_read),
        .ex_mem_rd        (ex_mem_rd),
        .ex_mem_write_reg (ex_mem_write_reg),
        .branch_taken     (branch_taken),
        .icache_miss      (icache_miss),
        .dcache_miss      (dcache_miss),
        .mem_ready        (mem_ready),
        .pc_stall         (pc_stall),
        .if_id_stall      (if_id_stall),
        .id_ex_stall      (id_ex_stall),
        .ex_mem_stall     (ex_mem_stall),
        .if_id_flush      (if_id_flush),
        .id_ex_flush      (id_ex_flush),
        .mem_wb_flush     (mem_wb_flush),
        .mem_sel          (mem_sel),
        .stall_cycles     (stall_cycles)
    );

    always #5 clk = ~clk;

    // {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush, mem_wb_flush, mem_sel}
    assign dut_out = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                      if_id_flush, id_ex_flush, mem_wb_flush, mem_sel};

    localparam logic [7:0] O_IDLE   = 8'b0000_0000;
    localparam logic [7:0] O_HAZ    = 8'b1100_0100;
    localparam logic [7:0] O_BRFL   = 8'b0000_1000;
    localparam logic [7:0] O_DFILL  = 8'b1111_0011;
    localparam logic [7:0] O_IFILL  = 8'b1000_1000;
    localparam logic [7:0] O_IDFILL = 8'b1111_1010;

`ifdef MEM_MEM_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam int M_RUN   = 0;
    localparam int M_IFILL = 1;
    localparam int M_DFILL = 2;

    int         n_chk  = 0;
    int         n_fail = 0;
    int         m_mode = M_RUN;
    int         m_cnt  = 0;
    logic [7:0] last_out;
    int         base;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_out();
        bit rs_dep_ex, rt_dep_ex, lu, br;
        if (rst) return O_IDLE;
        rs_dep_ex = (id_ex_rd != 0) && (id_ex_rd == if_id_rs);
        rt_dep_ex = (id_ex_rd != 0) && (id_ex_rd == if_id_rt);
        lu = id_ex_mem_read && (rs_dep_ex || (rt_dep_ex && !(FWD && if_id_store)));
        br = if_id_branch && (if_id_rs != 0) &&
             ((id_ex_write_reg && id_ex_rd == if_id_rs) ||
              (ex_mem_write_reg && ex_mem_rd == if_id_rs));
        if (m_mode == M_DFILL) return O_DFILL;
        if (m_mode == M_IFILL) return dcache_miss ? O_IDFILL : O_IFILL;
        if (lu || br) return O_HAZ;
        if (branch_taken) return O_BRFL;
        return O_IDLE;
    endfunction

    // Called just after a rising edge with inputs set; checks at the falling
    // edge, advances the model on the next rising edge.
    task automatic cycle(input string tag, input bit do_chk);
        logic [7:0] e;
        @(negedge clk);
        e = exp_out();
        last_out = dut_out;
        if (do_chk) begin
            chk({tag, "_ctl"}, dut_out, e);
            chk({tag, "_cnt"}, stall_cycles, m_cnt);
        end
        @(posedge clk);
        if (!rst) begin
            if (e[7] && m_cnt < 65535) m_cnt++;
            case (m_mode)
                M_RUN:   if (dcache_miss) m_mode = M_DFILL;
                         else if (icache_miss) m_mode = M_IFILL;
                M_DFILL: if (mem_ready) m_mode = icache_miss ? M_IFILL : M_RUN;
                default: if (mem_ready) m_mode = dcache_miss ? M_DFILL : M_RUN;
            endcase
        end
        #1;
    endtask

    task automatic clear_in();
        if_id_rs = 0; if_id_rt = 0; if_id_branch = 0; if_id_store = 0;
        id_ex_rd = 0; id_ex_write_reg = 0; id_ex_mem_read = 0;
        ex_mem_rd = 0; ex_mem_write_reg = 0; branch_taken = 0;
        icache_miss = 0; dcache_miss = 0; mem_ready = 0;
    endtask

    initial begin
        rst = 1'b1;
        clear_in();
        // Hazard present while in reset must not leak to the outputs.
        id_ex_mem_read = 1; id_ex_rd = 3; if_id_rs = 3; branch_taken = 1;
        #12;
        chk("rst_out", dut_out, O_IDLE);
        chk("rst_cnt", stall_cycles, 16'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        clear_in();
        cycle("idle", 1);

        // Load r3 in EX, ID reads r3.
        id_ex_mem_read = 1; id_ex_write_reg = 1; id_ex_rd = 3; if_id_rs = 3; if_id_rt = 7;
        base = stall_cycles;
        cycle("lu", 1);
        chk("lu_out", last_out, O_HAZ);
        clear_in();
        cycle("lu_after", 1);
        chk("lu_after_out", last_out, O_IDLE);
        chk("lu_inc", stall_cycles, base + 1);

        // Store of r5 data right behind load r5.
        id_ex_mem_read = 1; id_ex_write_reg = 1; id_ex_rd = 5;
        if_id_store = 1; if_id_rs = 1; if_id_rt = 5;
        cycle("st", 1);
        chk("st_out", last_out, FWD ? O_IDLE : O_HAZ);
        if_id_store = 0;
        cycle("rt_nostore", 1);
        chk("rt_nostore_out", last_out, O_HAZ);

        // r0 never causes a hazard.
        clear_in();
        id_ex_mem_read = 1; id_ex_write_reg = 1; id_ex_rd = 0; if_id_branch = 1;
        ex_mem_write_reg = 1; ex_mem_rd = 0;
        cycle("r0", 1);
        chk("r0_out", last_out, O_IDLE);

        // Branch on r2 behind an ALU write of r2: two stalls, then flush.
        clear_in();
        if_id_branch = 1; if_id_rs = 2; branch_taken = 1;
        id_ex_rd = 2; id_ex_write_reg = 1;
        cycle("br1", 1);
        chk("br1_out", last_out, O_HAZ);
        id_ex_rd = 0; id_ex_write_reg = 0; ex_mem_rd = 2; ex_mem_write_reg = 1;
        cycle("br2", 1);
        chk("br2_out", last_out, O_HAZ);
        ex_mem_rd = 0; ex_mem_write_reg = 0;
        cycle("br3", 1);
        chk("br3_out", last_out, O_BRFL);

        // Simultaneous misses: dcache first, then icache, 4 cycles each.
        clear_in();
        icache_miss = 1; dcache_miss = 1;
        cycle("both", 1);
        chk("both_out", last_out, O_IDLE);
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            cycle("dfill", 1);
            chk("dfill_out", last_out, O_DFILL);
        end
        dcache_miss = 0;
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            cycle("ifill", 1);
            chk("ifill_out", last_out, O_IFILL);
        end
        clear_in();
        cycle("back_run", 1);
        chk("back_run_out", last_out, O_IDLE);

        // Data miss raised during an ifetch fill.
        icache_miss = 1;
        cycle("imiss_req", 1);
        icache_miss = 0; dcache_miss = 1;
        cycle("imiss_d", 1);
        chk("imiss_d_out", last_out, O_IDFILL);
        mem_ready = 1;
        cycle("imiss_d_done", 1);
        chk("imiss_d_done_out", last_out, O_IDFILL);
        dcache_miss = 0;
        cycle("dfill_tail", 1);
        chk("dfill_tail_out", last_out, O_DFILL);
        clear_in();
        cycle("run2", 1);

        // Reset in the middle of a data fill.
        dcache_miss = 1;
        cycle("dreq", 1);
        cycle("dmid", 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_out", dut_out, O_IDLE);
        chk("mid_rst_cnt", stall_cycles, 16'h0);
        m_mode = M_RUN;
        m_cnt  = 0;
        cycle("in_rst", 1);
        rst = 1'b0;
        dcache_miss = 0;
        cycle("post_rst", 1);
        chk("post_rst_out", last_out, O_IDLE);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if_id_rs         = 4'($urandom_range(0, 7));
            if_id_rt         = 4'($urandom_range(0, 7));
            id_ex_rd         = 4'($urandom_range(0, 7));
            ex_mem_rd        = 4'($urandom_range(0, 7));
            if_id_branch     = ($urandom_range(0, 3) == 0);
            if_id_store      = ($urandom_range(0, 3) == 0);
            id_ex_write_reg  = $urandom_range(0, 1) == 1;
            id_ex_mem_read   = $urandom_range(0, 1) == 1;
            ex_mem_write_reg = $urandom_range(0, 1) == 1;
            branch_taken     = $urandom_range(0, 1) == 1;
            icache_miss      = ($urandom_range(0, 9) == 0);
            dcache_miss      = ($urandom_range(0, 9) == 0);
            mem_ready        = ($urandom_range(0, 2) == 0);
            cycle("rnd", 1);
        end

        // Counter saturation under a long ifetch stall.
        clear_in();
        mem_ready = 1;
        for (int i = 0; i < 8 && m_mode != M_RUN; i++) cycle("drain", 1);
        mem_ready = 0;
        icache_miss = 1;
        for (int i = 0; i < 70000; i++) cycle("sat", 0);
        chk("sat_model", m_cnt, 65535);
        cycle("sat_end", 1);
        chk("sat_cnt", stall_cycles, 16'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have: if_id_rs, if_id_rt  in  4 each  source registers of the instruction in ID.
REQ-004 SHALL have: if_id_branch  in  1  ID instruction is a register-target branch (reads rs); if_id_store  in  1  ID instruction is a store (rt is store data).
REQ-005 SHALL have: id_ex_rd  in  4; id_ex_write_reg  in  1; id_ex_mem_read  in  1  (EX-stage destination, write enable, load flag).
REQ-006 SHALL have: ex_mem_rd  in  4; ex_mem_write_reg  in  1  (MEM-stage destination, write enable).
REQ-007 SHALL have: branch_taken  in  1  branch resolved taken in ID; icache_miss, dcache_miss  in  1 each; mem_ready  in  1  memory port completes the current fill this cycle.
REQ-008 SHALL have: pc_stall, if_id_stall, id_ex_stall, ex_mem_stall  out  1 each  hold the named register.
REQ-009 SHALL have: if_id_flush, id_ex_flush, mem_wb_flush  out  1 each  load a bubble into the named register.
REQ-010 SHALL have: mem_sel  out  1  memory port owner (0 = icache, 1 = dcache); stall_cycles  out  16  saturating count of cycles with pc_stall high.

Function
REQ-011 SHALL implement FSM states RUN, IMISS, DMISS.
REQ-012 In RUN, dcache_miss SHALL move to DMISS; otherwise icache_miss SHALL move to IMISS; dcache wins when both are asserted in the same cycle.
REQ-013 In DMISS, pc/if_id/id_ex/ex_mem stalls SHALL be high, mem_wb_flush high, mem_sel=1; on mem_ready go to IMISS if icache_miss is high, else RUN.
REQ-014 In IMISS without dcache_miss, pc_stall and if_id_flush SHALL be high, the back end SHALL flow, mem_sel=0; on mem_ready go to DMISS if dcache_miss is high, else RUN.
REQ-015 In IMISS with dcache_miss high, all DMISS freeze outputs SHALL also assert; mem_sel stays 0 until the ifetch fill completes.
REQ-016 Load-use hazard (RUN only): id_ex_mem_read, id_ex_rd!=0, and id_ex_rd equals if_id_rs, or equals if_id_rt (subject to REQ-025) -> pc_stall, if_id_stall, id_ex_flush for that cycle.
REQ-017 Branch hazard (RUN only): if_id_branch and if_id_rs!=0 matching id_ex_rd with id_ex_write_reg, or ex_mem_rd with ex_mem_write_reg -> same stall as REQ-016; a load in EX thus yields 2 stall cycles.
REQ-018 branch_taken SHALL assert if_id_flush only in RUN with no REQ-016/017 stall; a stalled branch SHALL not flush.
REQ-019 Register 0 SHALL never create a hazard.
REQ-020 Hazard decode SHALL be combinational (0-cycle latency); only state and stall_cycles are registered.
REQ-021 stall_cycles SHALL increment on each clock with pc_stall high and hold at 16'hFFFF.

Reset
REQ-022 rst SHALL asynchronously force state=RUN, stall_cycles=0.
REQ-023 While rst is high, all stall/flush outputs SHALL be 0 and mem_sel=0.
REQ-024 Reset during IMISS/DMISS SHALL abandon the fill; RUN resumes on the first clock after release.

Configuration
REQ-025 Macro MEM_MEM_FWD_EN defined: an rt-only match with if_id_store high SHALL NOT stall (mem-to-mem forwarding supplies the data); undefined: it SHALL stall one cycle as in REQ-016.

Structure
REQ-026 Shared package wisc_pipe_pkg SHALL hold the state enum (RUN/IMISS/DMISS), REG_ZERO (4'h0), and the forwarding select encodings (2'b10 EX, 2'b01 MEM, 2'b00 none).
REQ-027 Combinational REQ-016/017/019/025 logic SHALL live in sub-module hazard_detect; FSM, mux and counter in hazard_ctrl.

Verification
REQ-028 Load r3 in EX, ID add rs=r3 -> 1 cycle pc_stall/if_id_stall/id_ex_flush, stall_cycles +1.
REQ-029 Load r5 in EX, ID store rt=r5, rs=r1 -> stall 1 cycle without MEM_MEM_FWD_EN, 0 cycles with it.
REQ-030 Branch rs=r2, r2 written by ALU op in EX -> 2 stall cycles, no flush; on 3rd cycle branch_taken -> if_id_flush=1.
REQ-031 icache_miss and dcache_miss same cycle, mem_ready after 4 cycles each -> DMISS 4 cycles (mem_sel=1), IMISS 4 cycles (mem_sel=0), then RUN.
REQ-032 rst asserted mid-DMISS -> outputs 0, stall_cycles=0 immediately, RUN after release; 70000 forced stall cycles -> stall_cycles=16'hFFFF.
